data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Responder on the CPU's data-memory port. Each cycle it decodes the CPU address: addresses below `IO_BASE` are forwarded to the backing data RAM; addresses at or above `IO_BASE` reach an I/O page. The I/O page holds a GPIO output register, a free-running timer with a compare flag, and a transmit FIFO drained by a downstream consumer through a valid/ready handshake. It sits between the CPU's `ram_*` port and the data RAM, and adds no wait states.

## Interface
- `DATA_WIDTH`, 16, bus data width
- `ADDR_WIDTH`, 12, bus address width
- `IO_BASE`, 12'hF00, first address of the I/O page
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, ≥2
- `i_clk`  in  1  clock; all state changes on the rising edge
- `i_rst`  in  1  reset, asynchronous, active-low
- `i_addr`  in  ADDR_WIDTH  CPU address
- `i_data`  in  DATA_WIDTH  CPU write data
- `i_we`  in  1  CPU write enable
- `o_data`  out  DATA_WIDTH  read data to CPU
- `mem_addr`  out  ADDR_WIDTH  backing RAM address
- `mem_dout`  out  DATA_WIDTH  backing RAM write data
- `mem_we`  out  1  backing RAM write enable
- `mem_din`  in  DATA_WIDTH  backing RAM read data
- `o_gpio`  out  DATA_WIDTH  GPIO output register
- `o_tmr_flag`  out  1  timer match flag (sticky)
- `o_tx_data`  out  DATA_WIDTH  FIFO head
- `o_tx_valid`  out  1  FIFO non-empty
- `i_tx_ready`  in  1  consumer accepts head

## Operation
- **RAM region** (`i_addr < IO_BASE`):
  - `mem_addr = i_addr`, `mem_dout = i_data`.
  - `mem_we = i_we`; `mem_we` is 0 for I/O addresses.
  - `o_data = mem_din`.
- **I/O page offsets** (offset = `i_addr - IO_BASE`):
  - +0 GPIO: read/write.
  - +1 TCNT: reads the counter; a write loads the counter.
  - +2 TCMP: compare value, read/write.
  - +3 STATUS: bit0 match, bit1 full, bit2 empty, bit3 overflow, bits[3+W:4] FIFO count (W = log2(FIFO_DEPTH)+1), other bits 0. Writing 1 to bit0 or bit3 clears that bit; other bits are read-only.
  - +4 TXD: a write pushes data; a read returns 0.
  - Other offsets: read 0, writes ignored.
- **Reads**: never have side effects, so the CPU may sample the same address repeatedly.
- **Timer**:
  - TCNT increments every cycle and wraps from all-ones to 0.
  - A write to TCNT overrides the increment for that cycle.
  - When TCNT == TCMP at a rising edge, the match flag sets. If set and a W1C clear occur in the same cycle, set wins.
- **FIFO**:
  - Push happens on a TXD write when not full, or when full and a pop occurs in the same cycle (count unchanged).
  - A TXD write while full with no pop drops the data and sets overflow.
  - Pop happens when `o_tx_valid && i_tx_ready`.
  - Pointers wrap modulo FIFO_DEPTH.
  - `o_tx_data` shows the head entry; its value is undefined-free: storage is reset to 0.
- **Reset** (async, `i_rst` = 0):
  - GPIO = 0, TCNT = 0, TCMP = all-ones.
  - Match and overflow flags = 0; FIFO empty (pointers and count 0, storage 0).
  - Outputs: `o_tx_valid` = 0, `o_tx_data` = 0, `o_tmr_flag` = 0, `o_gpio` = 0.
  - Reset mid-transfer discards FIFO contents.

## Timing
- Read path is combinational: `o_data` is valid in the same cycle as `i_addr`, with zero latency, because the CPU loads it into its top-of-stack at the next edge.
- Writes take effect at the rising edge where `i_we` = 1. The new value is readable in the next cycle.
- Timer and flag timing:
  - TCNT reads N in cycle k and N+1 in cycle k+1.
  - A match flag set at edge k is visible on STATUS and `o_tmr_flag` in cycle k+1.
- FIFO timing:
  - A push at edge k raises `o_tx_valid` in cycle k+1.
  - A pop at edge k advances `o_tx_data` in cycle k+1.
  - `o_tx_valid`, `o_tx_data`, `o_gpio` and `o_tmr_flag` are registered outputs. The handshake has no combinational path from `i_tx_ready`.
- Full/empty/count in STATUS reflect registered state, i.e. before the current cycle's push/pop.

## Test plan
- **RAM/GPIO decode**:
  - Write 0x1234 to 0x010 → `mem_we` = 1, `mem_addr` = 0x010, GPIO unchanged.
  - Write 0xA5A5 to 0xF00 → `mem_we` = 0, `o_gpio` = 0xA5A5 next cycle, read of 0xF00 returns 0xA5A5.
  - Read of 0xF07 returns 0.
- **Timer**:
  - Write TCMP = 5, TCNT = 0 → flag sets at the edge where TCNT = 5; `o_tmr_flag` = 1 one cycle later.
  - Write STATUS = 0x0001 → flag clears.
  - Repeat with the clear coinciding with a match → flag stays 1.
  - Load TCNT = 0xFFFF → next read 0x0000.
- **FIFO fill, hold `i_tx_ready` = 0**:
  - Push 1, 2, 3, 4 → STATUS full = 1, count = 4.
  - Push 5 → dropped, overflow = 1, head still 1.
  - W1C bit3 → overflow = 0.
- **FIFO drain**:
  - Assert `i_tx_ready` → `o_tx_data` 1, 2, 3, 4 on consecutive cycles.
  - `o_tx_valid` falls after 4 pops; STATUS empty = 1.
- **Simultaneous push/pop when full**:
  - Write 9 while popping → count stays 4; 9 emerges after the three older entries.
- **Async reset mid-operation**:
  - Assert `i_rst` = 0 with FIFO half full and GPIO ≠ 0 → immediately `o_tx_valid` = 0, `o_gpio` = 0, TCNT = 0, TCMP = 0xFFFF, STATUS = empty.

Source files
------------

// File: rtl/data_bus_responder.sv
// Data-memory port responder: passes low addresses to the backing RAM and
// decodes an I/O page holding GPIO, a compare timer and a transmit FIFO.
module data_bus_responder #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 12'hF00,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_we,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_din,
  output logic [DATA_WIDTH-1:0] o_gpio,
  output logic                  o_tmr_flag,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_GPIO   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_TCNT   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_TCMP   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] OFF_TXD    = ADDR_WIDTH'(4);

  logic [DATA_WIDTH-1:0] gpio_q, gpio_d;
  logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [DATA_WIDTH-1:0] tcmp_q, tcmp_d;
  logic                  match_q, match_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  is_io;
  logic [ADDR_WIDTH-1:0] io_off;
  logic                  gpio_we, tcnt_we, tcmp_we, status_we, txd_we;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] status;

  assign is_io  = (i_addr >= IO_BASE);
  assign io_off = i_addr - IO_BASE;

  assign gpio_we   = is_io && i_we && (io_off == OFF_GPIO);
  assign tcnt_we   = is_io && i_we && (io_off == OFF_TCNT);
  assign tcmp_we   = is_io && i_we && (io_off == OFF_TCMP);
  assign status_we = is_io && i_we && (io_off == OFF_STATUS);
  assign txd_we    = is_io && i_we && (io_off == OFF_TXD);

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && i_tx_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push  = txd_we && (!full || pop);

  assign mem_addr = i_addr;
  assign mem_dout = i_data;
  assign mem_we   = i_we && !is_io;

  always_comb begin
    status             = '0;
    status[0]          = match_q;
    status[1]          = full;
    status[2]          = empty;
    status[3]          = ovf_q;
    status[3+CW:4]     = count_q;
  end

  always_comb begin
    o_data = '0;
    if (!is_io) begin
      o_data = mem_din;
    end else begin
      case (io_off)
        OFF_GPIO:   o_data = gpio_q;
        OFF_TCNT:   o_data = tcnt_q;
        OFF_TCMP:   o_data = tcmp_q;
        OFF_STATUS: o_data = status;
        default:    o_data = '0;
      endcase
    end
  end

  always_comb begin
    gpio_d = gpio_we ? i_data : gpio_q;
    tcmp_d = tcmp_we ? i_data : tcmp_q;
    tcnt_d = tcnt_we ? i_data : tcnt_q + DATA_WIDTH'(1);

    // Flag sets take priority over a software clear in the same cycle.
    match_d = match_q;
    if (status_we && i_data[0]) match_d = 1'b0;
    if (tcnt_q == tcmp_q)       match_d = 1'b1;

    ovf_d = ovf_q;
    if (status_we && i_data[3])   ovf_d = 1'b0;
    if (txd_we && full && !pop)   ovf_d = 1'b1;

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = i_data;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      gpio_q   <= '0;
      tcnt_q   <= '0;
      tcmp_q   <= '1;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      gpio_q   <= gpio_d;
      tcnt_q   <= tcnt_d;
      tcmp_q   <= tcmp_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) fifo_q[gi] <= '0;
      else        fifo_q[gi] <= fifo_d[gi];
    end
  end

  assign o_gpio     = gpio_q;
  assign o_tmr_flag = match_q;
  assign o_tx_valid = !empty;
  assign o_tx_data  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: decode, timer, FIFO and async reset,
// with expected values worked out by hand.
module tb_data_bus_responder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [11:0] i_addr = '0;
  logic [15:0] i_data = '0;
  logic        i_we = 1'b0;
  logic [15:0] o_data;
  logic [11:0] mem_addr;
  logic [15:0] mem_dout;
  logic        mem_we;
  logic [15:0] mem_din = 16'hBEEF;
  logic [15:0] o_gpio;
  logic        o_tmr_flag;
  logic [15:0] o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  data_bus_responder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data), .i_we(i_we),
    .o_data(o_data), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we),
    .mem_din(mem_din), .o_gpio(o_gpio), .o_tmr_flag(o_tmr_flag),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %0d %s observed=%h expected=%h", checks, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    i_addr = a; i_data = d; i_we = 1'b1;
    step();
    i_we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [15:0] d);
    i_addr = a; i_we = 1'b0;
    #1;
    d = o_data;
  endtask

  logic [15:0] r;

  initial begin
    // Reset held: state must read back its reset values.
    #12;
    chk("rst_valid", 16'(o_tx_valid), 16'h0);
    chk("rst_gpio", o_gpio, 16'h0);
    chk("rst_flag", 16'(o_tmr_flag), 16'h0);
    chk("rst_txdata", o_tx_data, 16'h0);
    rd(12'hF01, r); chk("rst_tcnt", r, 16'h0000);
    rd(12'hF02, r); chk("rst_tcmp", r, 16'hFFFF);
    rd(12'hF03, r); chk("rst_status", r, 16'h0004);
    i_rst = 1'b1;
    step();

    // RAM region write passes through.
    i_addr = 12'h010; i_data = 16'h1234; i_we = 1'b1;
    #1;
    chk("ram_we", 16'(mem_we), 16'h1);
    chk("ram_addr", 16'(mem_addr), 16'h0010);
    chk("ram_dout", mem_dout, 16'h1234);
    chk("ram_rdata", o_data, 16'hBEEF);
    step();
    i_we = 1'b0;
    chk("ram_gpio_same", o_gpio, 16'h0);

    // GPIO write.
    i_addr = 12'hF00; i_data = 16'hA5A5; i_we = 1'b1;
    #1;
    chk("gpio_mem_we", 16'(mem_we), 16'h0);
    step();
    i_we = 1'b0;
    chk("gpio_out", o_gpio, 16'hA5A5);
    rd(12'hF00, r); chk("gpio_rd", r, 16'hA5A5);
    rd(12'hF07, r); chk("unmapped_rd", r, 16'h0000);
    rd(12'hF04, r); chk("txd_rd", r, 16'h0000);

    // Timer match: TCNT 0..5, flag sets at the edge with TCNT=5.
    wr(12'hF01, 16'h0100);
    wr(12'hF02, 16'h0005);
    wr(12'hF01, 16'h0000);
    rd(12'hF01, r); chk("tcnt_load0", r, 16'h0000);
    for (int i = 0; i < 5; i++) step();
    rd(12'hF01, r); chk("tcnt_at5", r, 16'h0005);
    chk("flag_not_yet", 16'(o_tmr_flag), 16'h0);
    step();
    chk("flag_set", 16'(o_tmr_flag), 16'h1);
    rd(12'hF03, r); chk("status_match", r, 16'h0005);
    wr(12'hF03, 16'h0001);
    chk("flag_cleared", 16'(o_tmr_flag), 16'h0);

    // Clear coinciding with match: set wins.
    wr(12'hF01, 16'h0003);
    step(); step();
    rd(12'hF01, r); chk("tcnt_at5_b", r, 16'h0005);
    wr(12'hF03, 16'h0001);
    chk("flag_set_wins", 16'(o_tmr_flag), 16'h1);
    wr(12'hF03, 16'h0001);
    chk("flag_cleared_b", 16'(o_tmr_flag), 16'h0);

    // Counter wrap.
    wr(12'hF01, 16'hFFFF);
    rd(12'hF01, r); chk("tcnt_ffff", r, 16'hFFFF);
    step();
    rd(12'hF01, r); chk("tcnt_wrap", r, 16'h0000);
    wr(12'hF02, 16'h8000);

    // FIFO fill with consumer stalled.
    for (int k = 1; k <= 4; k++) wr(12'hF04, 16'(k));
    rd(12'hF03, r); chk("fifo_full", r, 16'h0042);
    chk("fifo_valid", 16'(o_tx_valid), 16'h1);
    chk("fifo_head", o_tx_data, 16'h0001);
    wr(12'hF04, 16'h0005);
    rd(12'hF03, r); chk("fifo_ovf", r, 16'h004A);
    chk("fifo_head_kept", o_tx_data, 16'h0001);
    wr(12'hF03, 16'h0008);
    rd(12'hF03, r); chk("ovf_clear", r, 16'h0042);

    // Drain.
    i_tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain_data%0d", k), o_tx_data, 16'(k));
      step();
    end
    i_tx_ready = 1'b0;
    chk("drain_valid", 16'(o_tx_valid), 16'h0);
    rd(12'hF03, r); chk("drain_status", r, 16'h0004);

    // Push while full and popping.
    for (int k = 5; k <= 8; k++) wr(12'hF04, 16'(k));
    i_addr = 12'hF04; i_data = 16'h0009; i_we = 1'b1; i_tx_ready = 1'b1;
    step();
    i_we = 1'b0; i_tx_ready = 1'b0;
    rd(12'hF03, r); chk("pushpop_status", r, 16'h0042);
    chk("pushpop_head", o_tx_data, 16'h0006);
    i_tx_ready = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      chk($sformatf("pushpop_data%0d", k), o_tx_data, 16'(k));
      step();
    end
    i_tx_ready = 1'b0;
    chk("pushpop_empty", 16'(o_tx_valid), 16'h0);

    // Asynchronous reset mid-operation.
    wr(12'hF00, 16'h5A5A);
    wr(12'hF04, 16'h0011);
    wr(12'hF04, 16'h0022);
    chk("pre_rst_valid", 16'(o_tx_valid), 16'h1);
    chk("pre_rst_gpio", o_gpio, 16'h5A5A);
    #2;
    i_rst = 1'b0;
    #1;
    chk("arst_valid", 16'(o_tx_valid), 16'h0);
    chk("arst_gpio", o_gpio, 16'h0000);
    chk("arst_txdata", o_tx_data, 16'h0000);
    rd(12'hF01, r); chk("arst_tcnt", r, 16'h0000);
    rd(12'hF02, r); chk("arst_tcmp", r, 16'hFFFF);
    rd(12'hF03, r); chk("arst_status", r, 16'h0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
